// File: rtl/sw_seq_pkg.sv
// Shared types and pattern helpers for the switch pattern sequencer.
// pat_of/last_of work on up to 16-bit patterns; callers truncate to their width.
package sw_seq_pkg;

   typedef enum logic [1:0] {
      MODE_BIN_UP = 2'd0,
      MODE_BIN_DN = 2'd1,
      MODE_WALK1  = 2'd2,
      MODE_GRAY   = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   localparam int MAX_WIDTH = 16;

   function automatic logic [15:0] pat_of(input mode_e mode, input logic [15:0] k, input int width);
      logic [15:0] allOnes;
      logic [15:0] pat;
      allOnes = 16'((17'd1 << width) - 17'd1);
      case (mode)
         MODE_BIN_UP: pat = k;
         MODE_BIN_DN: pat = allOnes - k;
         MODE_WALK1:  pat = 16'd1 << k;
         MODE_GRAY:   pat = k ^ (k >> 1);
         default:     pat = 16'd0;
      endcase
      return pat;
   endfunction

   // Index of the final step: one per bit for walking one, full code space otherwise.
   function automatic logic [15:0] last_of(input mode_e mode, input int width);
      logic [15:0] last;
      case (mode)
         MODE_WALK1: last = 16'(width - 1);
         default:    last = 16'((17'd1 << width) - 17'd1);
      endcase
      return last;
   endfunction

endpackage

// File: rtl/sw_pattern_sequencer_dwell_timer.sv
// Dwell timer: counts 0..DWELL-1 while enabled and flags the final cycle of each dwell.
module dwell_timer
   import sw_seq_pkg::*;
#(
   parameter int DWELL = 10
)
(
   input  logic iCLK_50,
   input  logic iRST_N,
   input  logic iEN,
   input  logic iCLR,
   output logic oTICK
);

   localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(DWELL - 1);

   logic [CW-1:0] cntR;

   // Dwell counter; clear has priority so a new run always starts from zero.
   always_ff @(posedge iCLK_50 or negedge iRST_N) begin
      if (!iRST_N) begin
         cntR <= {CW{1'b0}};
      end else if (iCLR) begin
         cntR <= {CW{1'b0}};
      end else if (iEN) begin
         if (cntR == LAST_CNT) begin
            cntR <= {CW{1'b0}};
         end else begin
            cntR <= cntR + CW'(1);
         end
      end else begin
         cntR <= cntR;
      end
   end

   assign oTICK = iEN && (cntR == LAST_CNT);

endmodule

// File: rtl/sw_pattern_sequencer.sv
// Switch pattern sequencer: steps through binary/Gray/walking-one patterns, each held
// for DWELL clocks, with start/abort/loop control and a one-cycle completion pulse.
module sw_pattern_sequencer
   import sw_seq_pkg::*;
#(
   parameter int WIDTH = 3,
   parameter int DWELL = 10
)
(
   input  logic             iCLK_50,
   input  logic             iRST_N,
   input  logic             iSTART,
   input  logic             iABORT,
   input  logic [1:0]       iMODE,
   input  logic             iLOOP,
   output logic [WIDTH-1:0] oPAT,
   output logic [WIDTH-1:0] oSTEP,
   output logic             oBUSY,
   output logic             oDONE
);

   state_e           stateR;
   state_e           nextStateS;
   mode_e            modeR;
   mode_e            modeNextS;
   logic [WIDTH-1:0] stepR;
   logic [WIDTH-1:0] stepNextS;
   logic [WIDTH-1:0] lastS;
   logic             tickS;
   logic             timerEnS;
   logic [WIDTH-1:0] patNextS;
   logic [WIDTH-1:0] stepOutNextS;
   logic             busyNextS;
   logic             doneNextS;

   // An abort stops the dwell count at once so the next run starts clean.
   assign timerEnS = (stateR == S_RUN) && !iABORT;
   assign lastS    = WIDTH'(last_of(modeR, WIDTH));

   dwell_timer #(
      .DWELL(DWELL)
   ) uDwell (
      .iCLK_50(iCLK_50),
      .iRST_N (iRST_N),
      .iEN    (timerEnS),
      .iCLR   (!timerEnS),
      .oTICK  (tickS)
   );

   // State, step, latched mode and the registered outputs.
   always_ff @(posedge iCLK_50 or negedge iRST_N) begin
      if (!iRST_N) begin
         stateR <= S_IDLE;
         modeR  <= MODE_BIN_UP;
         stepR  <= {WIDTH{1'b0}};
         oPAT   <= {WIDTH{1'b0}};
         oSTEP  <= {WIDTH{1'b0}};
         oBUSY  <= 1'b0;
         oDONE  <= 1'b0;
      end else begin
         stateR <= nextStateS;
         modeR  <= modeNextS;
         stepR  <= stepNextS;
         oPAT   <= patNextS;
         oSTEP  <= stepOutNextS;
         oBUSY  <= busyNextS;
         oDONE  <= doneNextS;
      end
   end

   // Next state, step index and mode latch.
   always_comb begin
      nextStateS = stateR;
      stepNextS  = stepR;
      modeNextS  = modeR;
      case (stateR)
         S_IDLE: begin
            stepNextS = {WIDTH{1'b0}};
            if (iSTART && !iABORT) begin
               nextStateS = S_RUN;
               modeNextS  = mode_e'(iMODE);
            end else begin
               nextStateS = S_IDLE;
            end
         end
         S_RUN: begin
            if (iABORT) begin
               nextStateS = S_IDLE;
               stepNextS  = {WIDTH{1'b0}};
            end else if (tickS) begin
               if (stepR == lastS) begin
                  stepNextS = {WIDTH{1'b0}};
                  if (iLOOP) begin
                     nextStateS = S_RUN;
                  end else begin
                     nextStateS = S_DONE;
                  end
               end else begin
                  stepNextS  = stepR + WIDTH'(1);
                  nextStateS = S_RUN;
               end
            end else begin
               nextStateS = S_RUN;
            end
         end
         S_DONE: begin
            nextStateS = S_IDLE;
            stepNextS  = {WIDTH{1'b0}};
         end
         default: begin
            nextStateS = S_IDLE;
            stepNextS  = {WIDTH{1'b0}};
         end
      endcase
   end

   // Output values for the coming cycle, decoded from the next state so they register with it.
   always_comb begin
      patNextS     = {WIDTH{1'b0}};
      stepOutNextS = {WIDTH{1'b0}};
      busyNextS    = 1'b0;
      doneNextS    = 1'b0;
      case (nextStateS)
         S_RUN: begin
            patNextS     = WIDTH'(pat_of(modeNextS, 16'(stepNextS), WIDTH));
            stepOutNextS = stepNextS;
            busyNextS    = 1'b1;
         end
         S_DONE: begin
            doneNextS = 1'b1;
         end
         default: begin
            busyNextS = 1'b0;
            doneNextS = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_sw_pattern_sequencer.sv
// Self-checking bench: three sequencers (DWELL 10, 1, 2) compared cycle by cycle
// against a pattern model computed directly from the mode formulas.
module tb_sw_pattern_sequencer;

   localparam int W = 3;

   logic clk = 1'b0;
   logic rstN;
   logic start10, start1, start2;
   logic abortS, loopS;
   logic [1:0] mode;
   logic [W-1:0] pat10, step10, pat1, step1, pat2, step2;
   logic busy10, done10, busy1, done1, busy2, done2;

   int checks = 0;
   int failures = 0;
   int sel = 0;

   logic [W-1:0] selPat, selStep;
   logic selBusy, selDone;

   always #5 clk = ~clk;

   sw_pattern_sequencer #(.WIDTH(W), .DWELL(10)) dut10 (
      .iCLK_50(clk), .iRST_N(rstN), .iSTART(start10), .iABORT(abortS), .iMODE(mode),
      .iLOOP(loopS), .oPAT(pat10), .oSTEP(step10), .oBUSY(busy10), .oDONE(done10));
   sw_pattern_sequencer #(.WIDTH(W), .DWELL(1)) dut1 (
      .iCLK_50(clk), .iRST_N(rstN), .iSTART(start1), .iABORT(abortS), .iMODE(mode),
      .iLOOP(loopS), .oPAT(pat1), .oSTEP(step1), .oBUSY(busy1), .oDONE(done1));
   sw_pattern_sequencer #(.WIDTH(W), .DWELL(2)) dut2 (
      .iCLK_50(clk), .iRST_N(rstN), .iSTART(start2), .iABORT(abortS), .iMODE(mode),
      .iLOOP(loopS), .oPAT(pat2), .oSTEP(step2), .oBUSY(busy2), .oDONE(done2));

   always_comb begin
      case (sel)
         0:       begin selPat = pat10; selStep = step10; selBusy = busy10; selDone = done10; end
         1:       begin selPat = pat1;  selStep = step1;  selBusy = busy1;  selDone = done1;  end
         default: begin selPat = pat2;  selStep = step2;  selBusy = busy2;  selDone = done2;  end
      endcase
   end

   function automatic int dwell_of(input int s);
      return (s == 0) ? 10 : ((s == 1) ? 1 : 2);
   endfunction

   function automatic int seq_len(input int m);
      return (m == 2) ? W : (2 ** W);
   endfunction

   function automatic int model_pat(input int m, input int k);
      case (m)
         0:       return k;
         1:       return (2 ** W - 1) - k;
         2:       return 2 ** k;
         default: return k ^ (k / 2);
      endcase
   endfunction

   task automatic drive_start(input int s, input logic v);
      case (s)
         0:       start10 = v;
         1:       start1 = v;
         default: start2 = v;
      endcase
   endtask

   // Full run from a start pulse; caller must be at a negedge with the selected DUT idle.
   task automatic run_seq(input int s, input int m, input int passes, input logic startInDone);
      int dw, per, total, k;
      logic [W-1:0] expP, prevP;
      sel = s;
      dw = dwell_of(s);
      per = seq_len(m) * dw;
      total = per * passes;
      mode = 2'(m);
      loopS = (passes > 1);
      prevP = '0;
      drive_start(s, 1'b1);
      for (int c = 0; c < total; c++) begin
         @(negedge clk);
         if (c == 0) drive_start(s, 1'b0);
         else drive_start(s, 1'($urandom_range(0, 1)));
         k = (c % per) / dw;
         expP = W'(model_pat(m, k));
         checks++;
         if (selBusy !== 1'b1) begin
            failures++;
            $display("FAIL busy s=%0d m=%0d c=%0d got %b want 1", s, m, c, selBusy);
         end
         checks++;
         if (selPat !== expP) begin
            failures++;
            $display("FAIL pat s=%0d m=%0d c=%0d got %b want %b", s, m, c, selPat, expP);
         end
         checks++;
         if (selStep !== W'(k)) begin
            failures++;
            $display("FAIL step s=%0d m=%0d c=%0d got %0d want %0d", s, m, c, selStep, k);
         end
         checks++;
         if (selDone !== 1'b0) begin
            failures++;
            $display("FAIL early_done s=%0d m=%0d c=%0d got %b want 0", s, m, c, selDone);
         end
         if (m == 3 && dw == 1 && c > 0) begin
            checks++;
            if ($countones(selPat ^ prevP) != 1) begin
               failures++;
               $display("FAIL gray_onebit c=%0d got %b after %b want one bit changed", c, selPat, prevP);
            end
         end
         prevP = selPat;
         loopS = ((c / per) < passes - 1);
      end
      @(negedge clk);
      drive_start(s, startInDone);
      checks++;
      if (selDone !== 1'b1 || selBusy !== 1'b0) begin
         failures++;
         $display("FAIL done_pulse s=%0d m=%0d got done=%b busy=%b want done=1 busy=0", s, m, selDone, selBusy);
      end
      checks++;
      if (selPat !== '0 || selStep !== '0) begin
         failures++;
         $display("FAIL done_outputs s=%0d got pat=%b step=%0d want 0", s, selPat, selStep);
      end
      @(negedge clk);
      drive_start(s, 1'b0);
      checks++;
      if (selDone !== 1'b0 || selBusy !== 1'b0 || selPat !== '0) begin
         failures++;
         $display("FAIL idle_after s=%0d got done=%b busy=%b pat=%b want 0", s, selDone, selBusy, selPat);
      end
   endtask

   task automatic test_reset();
      rstN = 1'b0;
      start10 = 1'b0; start1 = 1'b0; start2 = 1'b0;
      abortS = 1'b0; loopS = 1'b0; mode = 2'd0;
      repeat (2) @(negedge clk);
      checks++;
      if ({pat10, step10, busy10, done10, pat1, step1, busy1, done1, pat2, step2, busy2, done2} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got %b %b %b %b want all 0", pat10, step10, busy10, done10);
      end
      rstN = 1'b1;
      @(negedge clk);
      checks++;
      if (busy10 !== 1'b0 || busy1 !== 1'b0 || busy2 !== 1'b0) begin
         failures++;
         $display("FAIL idle_after_reset got %b%b%b want 000", busy10, busy1, busy2);
      end
   endtask

   task automatic test_abort();
      sel = 0;
      mode = 2'd0;
      loopS = 1'b0;
      start10 = 1'b1;
      for (int c = 0; c <= 35; c++) begin
         @(negedge clk);
         start10 = 1'b0;
         checks++;
         if (pat10 !== W'(c / 10) || busy10 !== 1'b1) begin
            failures++;
            $display("FAIL abort_prefix c=%0d got pat=%b busy=%b want %0d 1", c, pat10, busy10, c / 10);
         end
         if (c == 35) abortS = 1'b1;
      end
      @(negedge clk);
      abortS = 1'b0;
      checks++;
      if (busy10 !== 1'b0 || pat10 !== '0 || step10 !== '0 || done10 !== 1'b0) begin
         failures++;
         $display("FAIL abort_stop got busy=%b pat=%b step=%0d done=%b want 0", busy10, pat10, step10, done10);
      end
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         checks++;
         if (done10 !== 1'b0 || busy10 !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_done c=%0d got done=%b busy=%b want 0", c, done10, busy10);
         end
      end
      start10 = 1'b1;
      abortS = 1'b1;
      @(negedge clk);
      start10 = 1'b0;
      abortS = 1'b0;
      checks++;
      if (busy10 !== 1'b0 || pat10 !== '0) begin
         failures++;
         $display("FAIL start_abort_idle got busy=%b pat=%b want 0", busy10, pat10);
      end
      @(negedge clk);
      checks++;
      if (busy10 !== 1'b0) begin
         failures++;
         $display("FAIL start_abort_stays got busy=%b want 0", busy10);
      end
   endtask

   task automatic test_reset_midrun();
      sel = 0;
      mode = 2'd0;
      loopS = 1'b0;
      start10 = 1'b1;
      for (int c = 0; c <= 52; c++) begin
         @(negedge clk);
         start10 = 1'b0;
         checks++;
         if (pat10 !== W'(c / 10)) begin
            failures++;
            $display("FAIL midrun_prefix c=%0d got pat=%b want %0d", c, pat10, c / 10);
         end
      end
      #2 rstN = 1'b0;
      #1;
      checks++;
      if (pat10 !== '0 || step10 !== '0 || busy10 !== 1'b0 || done10 !== 1'b0) begin
         failures++;
         $display("FAIL async_reset got pat=%b step=%0d busy=%b done=%b want 0", pat10, step10, busy10, done10);
      end
      @(negedge clk);
      rstN = 1'b1;
      @(negedge clk);
      run_seq(0, 2, 1, 1'b0);
   endtask

   task automatic test_back_to_back();
      run_seq(1, 0, 1, 1'b1);
      run_seq(1, 1, 1, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++) begin
         run_seq(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                 int'($urandom_range(1, 2)), 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      test_reset();
      run_seq(0, 0, 1, 1'b0);   // binary up, DWELL=10
      run_seq(1, 3, 1, 1'b0);   // Gray, DWELL=1
      run_seq(2, 2, 1, 1'b0);   // walking one, DWELL=2
      run_seq(0, 1, 2, 1'b0);   // binary down, two looped passes
      test_abort();
      test_reset_midrun();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
